// File: rtl/determ_sub_sched.sv
// Deterministic bitstream subtractor scheduler: grants one requester per window,
// accumulates saturated +/-2*ONE steps, reports the sum. Optional: DETERM_SUB_SCHED_TIMEOUT_EN.
module determ_sub_sched #(
  parameter int NUM_REQ   = 4,
  parameter int BIT_WIDTH = 16,
  parameter int INT_WIDTH = 5,
  parameter int WIN_LEN   = 8
`ifdef DETERM_SUB_SCHED_TIMEOUT_EN
  , parameter int TIMEOUT = 16
`endif
) (
  input  logic                               CLK,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ-1:0]                 req_a,
  input  logic [NUM_REQ-1:0]                 req_b,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic                               res_valid,
  output logic signed [BIT_WIDTH-1:0]        res_data,
  output logic [$clog2(NUM_REQ)-1:0]         res_id,
  input  logic                               res_ready
`ifdef DETERM_SUB_SCHED_TIMEOUT_EN
  , output logic                             res_err
`endif
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(WIN_LEN + 1);
  localparam int FRAC  = BIT_WIDTH - INT_WIDTH - 1;
  localparam int EW    = BIT_WIDTH + 2;
  localparam logic signed [EW-1:0] STEP    = EW'(2 ** (FRAC + 1));
  localparam logic signed [EW-1:0] SAT_MAX = {3'b000, {(BIT_WIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0] SAT_MIN = {3'b111, {(BIT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                       state_q, state_d;
  logic [ID_W-1:0]              ptr_q, ptr_d;
  logic [ID_W-1:0]              sel_q, sel_d;
  logic signed [BIT_WIDTH-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;

  logic                         pick_found;
  logic [ID_W-1:0]              pick_idx;
  logic [ID_W-1:0]              scan_idx;
  int                           scan_int;
  logic                         hs;
  logic signed [EW-1:0]         d_ext;
  logic signed [EW-1:0]         sum_ext;
  logic signed [BIT_WIDTH-1:0]  acc_sat;

`ifdef DETERM_SUB_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmr_q, tmr_d;
  logic          err_q, err_d;
`endif

  // Round-robin scan starting at ptr, wrapping past NUM_REQ-1.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_int   = 0;
    scan_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_int = int'(ptr_q) + k;
      if (scan_int >= NUM_REQ) scan_int = scan_int - NUM_REQ;
      scan_idx = ID_W'(scan_int);
      if (!pick_found && req_valid[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    d_ext = '0;
    if (req_a[sel_q] && !req_b[sel_q])      d_ext = STEP;
    else if (!req_a[sel_q] && req_b[sel_q]) d_ext = -STEP;
    sum_ext = {{2{acc_q[BIT_WIDTH-1]}}, acc_q} + d_ext;
    if (sum_ext > SAT_MAX)      acc_sat = SAT_MAX[BIT_WIDTH-1:0];
    else if (sum_ext < SAT_MIN) acc_sat = SAT_MIN[BIT_WIDTH-1:0];
    else                        acc_sat = sum_ext[BIT_WIDTH-1:0];
  end

  assign hs = (state_q == S_RUN) && req_valid[sel_q];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    req_ready = '0;
    res_valid = 1'b0;
`ifdef DETERM_SUB_SCHED_TIMEOUT_EN
    tmr_d     = tmr_q;
    err_d     = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          sel_d   = pick_idx;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
`ifdef DETERM_SUB_SCHED_TIMEOUT_EN
          tmr_d   = TW'(TIMEOUT - 1);
          err_d   = 1'b0;
`endif
        end
      end
      S_RUN: begin
        req_ready[sel_q] = 1'b1;
        if (hs) begin
          acc_d = acc_sat;
          cnt_d = cnt_q + 1'b1;
`ifdef DETERM_SUB_SCHED_TIMEOUT_EN
          tmr_d = TW'(TIMEOUT - 1);
`endif
          if (cnt_q == CNT_W'(WIN_LEN - 1)) state_d = S_DONE;
        end
`ifdef DETERM_SUB_SCHED_TIMEOUT_EN
        // Stall timer: terminal count ends the window with the partial sum.
        else if (tmr_q == '0) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
`endif
      end
      S_DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          ptr_d   = (sel_q == ID_W'(NUM_REQ - 1)) ? '0 : sel_q + 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
`ifdef DETERM_SUB_SCHED_TIMEOUT_EN
      tmr_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
`ifdef DETERM_SUB_SCHED_TIMEOUT_EN
      tmr_q   <= tmr_d;
      err_q   <= err_d;
`endif
    end
  end

  assign res_data = acc_q;
  assign res_id   = sel_q;
`ifdef DETERM_SUB_SCHED_TIMEOUT_EN
  assign res_err  = err_q;
`endif

endmodule

// File: tb/tb_determ_sub_sched.sv
// Self-checking bench for determ_sub_sched: vector table, random windows against
// an arithmetic reference model, and hand sequences for arbitration, reset and saturation.
module tb_determ_sub_sched;
  localparam int NR  = 4;
  localparam int BW  = 16;
  localparam int WIN = 8;
  localparam int ONE = 1 << (BW - 5 - 1);

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req_valid, req_a, req_b, req_ready, ready32;
  logic          res_valid, res_ready, rv32;
  logic [BW-1:0] res_data, rd32;
  logic [1:0]    res_id, rid32;
`ifdef DETERM_SUB_SCHED_TIMEOUT_EN
  logic          res_err, err32;
`endif

  always #5 clk = ~clk;

  determ_sub_sched #(.NUM_REQ(NR), .BIT_WIDTH(BW), .INT_WIDTH(5), .WIN_LEN(WIN)
`ifdef DETERM_SUB_SCHED_TIMEOUT_EN
    , .TIMEOUT(16)
`endif
  ) u_dut (
    .CLK(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .res_valid(res_valid), .res_data(res_data),
    .res_id(res_id), .res_ready(res_ready)
`ifdef DETERM_SUB_SCHED_TIMEOUT_EN
    , .res_err(res_err)
`endif
  );

  determ_sub_sched #(.NUM_REQ(NR), .BIT_WIDTH(BW), .INT_WIDTH(5), .WIN_LEN(32)
`ifdef DETERM_SUB_SCHED_TIMEOUT_EN
    , .TIMEOUT(16)
`endif
  ) u_dut32 (
    .CLK(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(ready32), .res_valid(rv32), .res_data(rd32),
    .res_id(rid32), .res_ready(res_ready)
`ifdef DETERM_SUB_SCHED_TIMEOUT_EN
    , .res_err(err32)
`endif
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Reference: running sum of +/-2*ONE per pair, clamped to the 16-bit signed range after each step.
  function automatic logic [BW-1:0] model(input logic [WIN-1:0] av, input logic [WIN-1:0] bv);
    int s = 0;
    for (int j = 0; j < WIN; j++) begin
      s = s + 2 * ONE * (int'(av[j]) - int'(bv[j]));
      if (s > 32767)  s = 32767;
      if (s < -32768) s = -32768;
    end
    return BW'(s);
  endfunction

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_win(input int id, input logic [WIN-1:0] av, input logic [WIN-1:0] bv,
                         input int st_at, input int st_len, input int rdy_dly,
                         input logic [BW-1:0] exp, input string tag);
    int            k = 0;
    int            cyc = 0;
    int            st_left = st_len;
    logic          will_hs;
    logic          bad = 1'b0;
    logic [BW-1:0] d0;
    logic [1:0]    i0;
    logic [NR-1:0] oh;
    oh = NR'(1) << id;
    req_valid = oh; req_a[id] = av[0]; req_b[id] = bv[0]; res_ready = 1'b0;
    while (k < WIN && cyc < 200) begin
      will_hs = req_valid[id] && req_ready[id];
      if ((req_ready & ~oh) != '0 || res_valid) bad = 1'b1;
      @(negedge clk); cyc++;
      if (will_hs) k++;
      if (k < WIN) begin
        if (k == st_at && st_left > 0) begin req_valid[id] = 1'b0; st_left--; end
        else req_valid[id] = 1'b1;
        req_a[id] = av[k]; req_b[id] = bv[k];
      end else begin
        req_valid = '0;
      end
    end
    chk({tag, "_latency"}, {31'd0, res_valid}, 32'd1);
    d0 = res_data; i0 = res_id;
`ifdef DETERM_SUB_SCHED_TIMEOUT_EN
    chk({tag, "_err"}, {31'd0, res_err}, 32'd0);
`endif
    repeat (rdy_dly) begin
      @(negedge clk);
      if (!res_valid || res_data !== d0 || res_id !== i0) bad = 1'b1;
    end
    res_ready = 1'b1;
    @(negedge clk);
    if (res_valid) bad = 1'b1;
    res_ready = 1'b0;
    chk({tag, "_data"}, {16'd0, d0}, {16'd0, exp});
    chk({tag, "_id"}, {30'd0, i0}, id);
    chk({tag, "_protocol"}, {31'd0, bad}, 32'd0);
  endtask

  typedef struct {
    int             id;
    logic [WIN-1:0] av;
    logic [WIN-1:0] bv;
    int             st_at;
    int             st_len;
    int             rdy_dly;
    logic [BW-1:0]  exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{0, 8'hFF, 8'h00, 0, 0, 0, 16'h4000};
    vecs[1] = '{1, 8'h55, 8'hAA, 0, 0, 0, 16'h0000};
    vecs[2] = '{1, 8'hA5, 8'hA5, 0, 0, 1, 16'h0000};
    vecs[3] = '{2, 8'hFF, 8'h00, 3, 5, 3, 16'h4000};
    vecs[4] = '{3, 8'h00, 8'hFF, 0, 0, 1, 16'hC000};
    vecs[5] = '{0, 8'h0F, 8'h00, 2, 1, 0, 16'h2000};

    do_reset();
    chk("reset_ready", {28'd0, req_ready}, 32'd0);
    chk("reset_valid", {31'd0, res_valid}, 32'd0);
    chk("reset_data", {16'd0, res_data}, 32'd0);
    chk("reset_id", {30'd0, res_id}, 32'd0);

    for (int v = 0; v < 6; v++)
      run_win(vecs[v].id, vecs[v].av, vecs[v].bv, vecs[v].st_at, vecs[v].st_len,
              vecs[v].rdy_dly, vecs[v].exp, "vec");

    for (int r = 0; r < 8; r++) begin
      logic [WIN-1:0] av, bv;
      av = WIN'($urandom);
      bv = WIN'($urandom);
      run_win(int'($urandom_range(0, NR - 1)), av, bv, int'($urandom_range(1, WIN - 1)),
              int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), model(av, bv), "rand");
    end

    // All requesters valid: round-robin order and back-to-back turnaround.
    begin
      int   ids[5];
      int   at[5];
      int   n = 0;
      int   cyc = 0;
      logic bad = 1'b0;
      do_reset();
      req_valid = '1; req_a = '1; req_b = '0; res_ready = 1'b1;
      while (n < 5 && cyc < 200) begin
        @(negedge clk); cyc++;
        if (!$onehot0(req_ready)) bad = 1'b1;
        if (res_valid) begin
          ids[n] = int'(res_id); at[n] = cyc;
          if (res_data !== 16'h4000) bad = 1'b1;
          n++;
          if (n == 5) req_valid = '0;
        end
      end
      @(negedge clk);
      res_ready = 1'b0;
      chk("rr_count", n, 5);
      for (int j = 0; j < 5; j++) chk("rr_order", ids[j], j % NR);
      for (int j = 1; j < 5; j++) chk("rr_turnaround", at[j] - at[j-1], WIN + 2);
      chk("rr_onehot_data", {31'd0, bad}, 32'd0);
    end

    // Reset mid-window after three handshakes.
    do_reset();
    req_valid = 4'b0001; req_a = 4'b0001; req_b = '0;
    repeat (4) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_ready", {28'd0, req_ready}, 32'd0);
    chk("midrst_valid", {31'd0, res_valid}, 32'd0);
    chk("midrst_data", {16'd0, res_data}, 32'd0);
    chk("midrst_id", {30'd0, res_id}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_win(0, 8'hFF, 8'h00, 0, 0, 0, 16'h4000, "postrst");

    // Saturation with a 32-pair window.
    for (int s = 0; s < 2; s++) begin
      int   cyc = 0;
      logic bad = 1'b0;
      do_reset();
      req_valid = 4'b0001;
      req_a = (s == 0) ? 4'b0001 : 4'b0000;
      req_b = (s == 0) ? 4'b0000 : 4'b0001;
      while (!rv32 && cyc < 80) begin
        @(negedge clk); cyc++;
        if (!$onehot0(ready32)) bad = 1'b1;
      end
      chk("sat_valid", {31'd0, rv32}, 32'd1);
      chk("sat_data", {16'd0, rd32}, (s == 0) ? 32'h7FFF : 32'h8000);
      chk("sat_id", {30'd0, rid32}, 32'd0);
      chk("sat_onehot", {31'd0, bad}, 32'd0);
    end

`ifdef DETERM_SUB_SCHED_TIMEOUT_EN
    begin
      int cyc = 0;
      do_reset();
      req_valid = 4'b0001; req_a = 4'b0001; req_b = '0;
      repeat (4) @(negedge clk);
      req_valid = '0;
      while (!res_valid && cyc < 40) begin @(negedge clk); cyc++; end
      chk("tmo_valid", {31'd0, res_valid}, 32'd1);
      chk("tmo_data", {16'd0, res_data}, 32'h1800);
      chk("tmo_err", {31'd0, res_err}, 32'd1);
      chk("tmo_err32", {31'd0, err32}, 32'd1);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
